serial_adder: RTL and testbench

- Bit-serial WIDTH-bit adder built around the team's single-bit fulladder cell.
- Operands are loaded in parallel and fed LSB-first through the cell, one bit per clock, with a registered carry.
- The registered sum is presented in parallel at the end.
- Sits directly upstream of the fulladder cell: it sequences that cell's a/b/cin inputs and consumes its s/c outputs.

---
 rtl/serial_adder_pkg.sv | 12 +
 rtl/serial_adder_if.sv | 26 ++
 rtl/serial_adder_fulladder.sv | 11 +
 rtl/serial_adder.sv | 117 +++++++++++
 tb/tb_serial_adder.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/serial_adder_pkg.sv
// Shared constants for the bit-serial adder: FSM state encoding and default width.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int SA_WIDTH_DEF = 8;

endpackage

// File: rtl/serial_adder_if.sv
// Request/result bundle of the serial adder; master drives the request, slave returns the result.
interface serial_adder_if
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = SA_WIDTH_DEF
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/serial_adder_fulladder.sv
// Single-bit full adder cell used as the serial adder's bit datapath.
module fulladder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic c
);
    assign s = a ^ b ^ cin;
    assign c = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: operands shifted LSB-first through one full adder with a registered carry.
// Optional signed-overflow output is enabled by defining SERIAL_ADDER_OVF_EN; otherwise ovf reads 0.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = SA_WIDTH_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    serial_adder_if.slave bus
);
    localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_sr;
    logic [WIDTH-1:0] sum_q;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic             cout_q;
    logic             done_q;
    logic             ovf_q;
    logic             fa_s;
    logic             fa_c;

    fulladder u_fa (
        .a   (a_sr[0]),
        .b   (b_sr[0]),
        .cin (carry),
        .s   (fa_s),
        .c   (fa_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (bus.start) state_nxt = ST_RUN;
            ST_RUN:  if (cnt == CNT_LAST) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Shift datapath; the counter saturates on the last bit so it never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            sum_sr <= '0;
            sum_q  <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            cout_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        a_sr  <= bus.a;
                        b_sr  <= bus.b;
                        carry <= bus.cin;
                        cnt   <= '0;
                    end
                end
                ST_RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    sum_sr <= {fa_s, sum_sr[WIDTH-1:1]};
                    carry  <= fa_c;
                    if (cnt != CNT_LAST) cnt <= cnt + CNT_W'(1);
                end
                ST_DONE: begin
                    sum_q  <= sum_sr;
                    cout_q <= carry;
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    logic msb_carry;

    // Signed overflow is the carry into the MSB differing from the carry out of it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            msb_carry <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            if (state == ST_RUN && cnt == CNT_LAST) msb_carry <= carry;
            if (state == ST_DONE) ovf_q <= msb_carry ^ carry;
        end
    end
`else
    assign ovf_q = 1'b0;
`endif

    assign bus.busy = (state != ST_IDLE);
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder against an arithmetic reference (a + b + cin, signed overflow rule).
module tb_serial_adder;
    localparam int W = 8;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    serial_adder_if #(.WIDTH(W)) bus ();

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic ref_ovf(input logic [W-1:0] oa, input logic [W-1:0] ob,
                                     input logic [W-1:0] s);
`ifdef SERIAL_ADDER_OVF_EN
        return (oa[W-1] == ob[W-1]) && (s[W-1] != oa[W-1]);
`else
        return 1'b0;
`endif
    endfunction

    // One-cycle start, optional second start injected mid-run, then full result check.
    task automatic do_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic oc,
                         input int inject, input string tag);
        logic [W:0] full;
        int         seen;
        int         first;
        full  = (W+1)'(oa) + (W+1)'(ob) + (W+1)'(oc);
        seen  = 0;
        first = -1;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = oa;
        bus.b     = ob;
        bus.cin   = oc;
        @(posedge clk);
        #1;
        check({tag, ".busy"}, 32'(bus.busy), 32'd1);
        bus.start = 1'b0;
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
        bus.cin   = 1'($urandom);
        for (int i = 1; i <= 14; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                seen++;
                if (first < 0) first = i;
            end
            if (i == inject) begin
                bus.start = 1'b1;
                bus.a     = 8'hAA;
                bus.b     = 8'h55;
            end else if (i == inject + 1) begin
                bus.start = 1'b0;
            end
        end
        check({tag, ".ndone"}, 32'(seen), 32'd1);
        check({tag, ".lat"}, 32'(first), 32'(W + 1));
        check({tag, ".sum"}, 32'(bus.sum), 32'(full[W-1:0]));
        check({tag, ".cout"}, 32'(bus.cout), 32'(full[W]));
        check({tag, ".ovf"}, 32'(bus.ovf), 32'(ref_ovf(oa, ob, full[W-1:0])));
    endtask

    initial begin
        int done_at[$];
        int seen;
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.cin   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.busy", 32'(bus.busy), 32'd0);
        check("rst.done", 32'(bus.done), 32'd0);
        check("rst.sum", 32'(bus.sum), 32'd0);
        check("rst.cout", 32'(bus.cout), 32'd0);
        check("rst.ovf", 32'(bus.ovf), 32'd0);
        rst_n = 1'b1;

        do_op(8'h0F, 8'h01, 1'b0, 0, "op0f01");
        do_op(8'hFF, 8'h01, 1'b0, 0, "opff01");
        do_op(8'hFF, 8'hFF, 1'b1, 0, "opffff1");
        do_op(8'h7F, 8'h01, 1'b0, 0, "op7f01");
        do_op(8'hFF, 8'h01, 1'b0, 0, "opff01b");
        do_op(8'h12, 8'h34, 1'b0, 3, "ignstart");

        // Abort at RUN bit 4 with a nonzero result still held from the previous op.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'hC3;
        bus.b     = 8'h3C;
        bus.cin   = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort.busy", 32'(bus.busy), 32'd0);
        check("abort.sum", 32'(bus.sum), 32'd0);
        check("abort.cout", 32'(bus.cout), 32'd0);
        check("abort.done", 32'(bus.done), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen  = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) seen++;
        end
        check("abort.nodone", 32'(seen), 32'd0);
        do_op(8'h01, 8'h01, 1'b0, 0, "postabort");

        // Start held high: back-to-back operations every WIDTH+2 cycles.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'h80;
        bus.b     = 8'h80;
        bus.cin   = 1'b0;
        for (int i = 0; i < 32; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                done_at.push_back(i);
                check("held.sum", 32'(bus.sum), 32'h00);
                check("held.cout", 32'(bus.cout), 32'd1);
            end
        end
        bus.start = 1'b0;
        check("held.ndone", 32'(done_at.size()), 32'd3);
        for (int k = 0; k < done_at.size(); k++) begin
            check("held.when", 32'(done_at[k]), 32'(W + 1 + k * (W + 2)));
        end
        repeat (12) @(posedge clk);

        for (int r = 0; r < 20; r++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom), 0, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
